// File: rtl/ex_issue_ctrl.sv
// ex_issue_ctrl: ID->EX issue control.
// Tracks outstanding register writebacks in a per-register scoreboard
// (RAW/WAW hazards). Holds EX busy for multi-cycle ops with an occupancy
// counter. Produces ID stall, EX valid and a sticky bad-retire flag.
module ex_issue_ctrl #(
    parameter int W_RD     = 5,
    parameter int NREG     = 32,
    parameter int W_LAT    = 3,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              v_i,
    input  logic              wb_i,
    input  logic [W_RD-1:0]   rd_num_i,
    input  logic [1:0]        src_use_i,
    input  logic [W_RD-1:0]   rs_num_i,
    input  logic [W_RD-1:0]   rt_num_i,
    input  logic [W_LAT-1:0]  lat_i,
    input  logic              ret_i,
    input  logic [W_RD-1:0]   ret_num_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              issue_o,
    output logic              busy_o,
    output logic [NREG-1:0]   pend_o,
    output logic              err_o
);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t            r_state;
    logic [W_LAT-1:0]  r_cnt;
    logic [NREG-1:0]   r_pend;
    logic              r_err;

    logic              w_hz;
    logic              w_issue;
    logic              w_busy;
    logic              w_rd_zero;
    logic              w_ret_zero;
    logic              w_set;
    logic [W_LAT-1:0]  w_lat_eff;
    logic [NREG-1:0]   w_pend_nxt;

    // Hazard detection and issue/stall decision from current inputs and state
    always_comb begin
        w_busy     = (r_state == S_BUSY);
        w_hz       = (src_use_i[1] & r_pend[rs_num_i])
                   | (src_use_i[0] & r_pend[rt_num_i])
                   | (wb_i         & r_pend[rd_num_i]);
        w_issue    = v_i & ~flush_i & ~w_hz & ~w_busy;
        stall_o    = v_i & ~flush_i & (w_hz | w_busy);
        issue_o    = w_issue;
        w_lat_eff  = (lat_i == '0) ? W_LAT'(1) : lat_i;
        w_rd_zero  = (ZERO_REG != 0) && (rd_num_i == '0);
        w_ret_zero = (ZERO_REG != 0) && (ret_num_i == '0);
        w_set      = w_issue & wb_i & ~w_rd_zero;
    end

    // Next scoreboard value: clear on retire first, so a same-cycle set wins
    always_comb begin
        w_pend_nxt = r_pend;
        if (ret_i) begin
            w_pend_nxt[ret_num_i] = 1'b0;
        end
        if (w_set) begin
            w_pend_nxt[rd_num_i] = 1'b1;
        end
    end

    // Scoreboard and sticky error register; flush drops the retire entirely
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pend <= '0;
            r_err  <= 1'b0;
        end else if (flush_i) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            if (ret_i && !r_pend[ret_num_i] && !w_ret_zero) begin
                r_err <= 1'b1;
            end
        end
    end

    // Occupancy FSM: load L-1 on a multi-cycle issue, count down to idle
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else if (flush_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue && (w_lat_eff > W_LAT'(1))) begin
                        r_cnt   <= w_lat_eff - W_LAT'(1);
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - W_LAT'(1);
                    if (r_cnt == W_LAT'(1)) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign busy_o = (r_cnt != '0);
    assign pend_o = r_pend;
    assign err_o  = r_err;

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Testbench for ex_issue_ctrl: driver pushes expected outputs from a
// cycle-level reference model into a queue; a monitor pops and compares.
module tb_ex_issue_ctrl;

    localparam int W_RD  = 5;
    localparam int NREG  = 32;
    localparam int W_LAT = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              v_i;
    logic              wb_i;
    logic [W_RD-1:0]   rd_num_i;
    logic [1:0]        src_use_i;
    logic [W_RD-1:0]   rs_num_i;
    logic [W_RD-1:0]   rt_num_i;
    logic [W_LAT-1:0]  lat_i;
    logic              ret_i;
    logic [W_RD-1:0]   ret_num_i;
    logic              flush_i;
    logic              stall_o;
    logic              issue_o;
    logic              busy_o;
    logic [NREG-1:0]   pend_o;
    logic              err_o;

    always #5 clk = ~clk;

    ex_issue_ctrl #(
        .W_RD    (W_RD),
        .NREG    (NREG),
        .W_LAT   (W_LAT),
        .ZERO_REG(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .v_i       (v_i),
        .wb_i      (wb_i),
        .rd_num_i  (rd_num_i),
        .src_use_i (src_use_i),
        .rs_num_i  (rs_num_i),
        .rt_num_i  (rt_num_i),
        .lat_i     (lat_i),
        .ret_i     (ret_i),
        .ret_num_i (ret_num_i),
        .flush_i   (flush_i),
        .stall_o   (stall_o),
        .issue_o   (issue_o),
        .busy_o    (busy_o),
        .pend_o    (pend_o),
        .err_o     (err_o)
    );

    typedef struct packed {
        logic            stall;
        logic            issue;
        logic            busy;
        logic [NREG-1:0] pend;
        logic            err;
        logic [31:0]     cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: set of outstanding registers, sticky error, and the
    // first cycle at which EX is free again.
    bit   pm[NREG];
    bit   em = 1'b0;
    int   cyc = 0;
    int   free_at = 0;
    bit   mvalid = 1'b0;

    task automatic chk(input string name, input int c, input logic [NREG-1:0] act,
                       input logic [NREG-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: actual %h required %h", name, c, act, req);
        end
    endtask

    // One clock cycle of stimulus plus model prediction and update
    task automatic step(input bit r, input bit f, input bit v, input bit wb,
                        input int rd, input bit [1:0] su, input int rs, input int rt,
                        input int lat, input bit ret, input int rn);
        exp_t e;
        bit   hz;
        bit   bsy;
        bit   iss;
        int   len;
        @(negedge clk);
        rst       = r;
        flush_i   = f;
        v_i       = v;
        wb_i      = wb;
        rd_num_i  = W_RD'(rd);
        src_use_i = su;
        rs_num_i  = W_RD'(rs);
        rt_num_i  = W_RD'(rt);
        lat_i     = W_LAT'(lat);
        ret_i     = ret;
        ret_num_i = W_RD'(rn);

        bsy = (cyc < free_at);
        hz  = (su[1] && pm[rs]) || (su[0] && pm[rt]) || (wb && pm[rd]);
        iss = v && !f && !hz && !bsy;
        e.stall = v && !f && (hz || bsy);
        e.issue = iss;
        e.busy  = bsy;
        for (int i = 0; i < NREG; i++) e.pend[i] = pm[i];
        e.err   = em;
        e.cyc   = cyc;
        if (mvalid) q.push_back(e);

        if (!r) begin
            for (int i = 0; i < NREG; i++) pm[i] = 1'b0;
            em      = 1'b0;
            free_at = cyc + 1;
            mvalid  = 1'b1;
        end else if (f) begin
            for (int i = 0; i < NREG; i++) pm[i] = 1'b0;
            free_at = cyc + 1;
        end else begin
            if (ret) begin
                if (!pm[rn] && rn != 0) em = 1'b1;
                pm[rn] = 1'b0;
            end
            if (iss) begin
                if (wb && rd != 0) pm[rd] = 1'b1;
                len     = (lat == 0) ? 1 : lat;
                free_at = cyc + len;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int rn_ret, input bit ret);
        step(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, ret, rn_ret);
    endtask

    // Monitor: compare DUT outputs against the queued prediction each cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall_o", int'(e.cyc), NREG'(stall_o), NREG'(e.stall));
                chk("issue_o", int'(e.cyc), NREG'(issue_o), NREG'(e.issue));
                chk("busy_o",  int'(e.cyc), NREG'(busy_o),  NREG'(e.busy));
                chk("pend_o",  int'(e.cyc), pend_o,         e.pend);
                chk("err_o",   int'(e.cyc), NREG'(err_o),   NREG'(e.err));
            end
        end
    end

    initial begin
        int pl[$];
        bit r, f, v, wb, ret;
        int rd, rs, rt, lat, rn;
        bit [1:0] su;

        rst = 1'b0; flush_i = 1'b0; v_i = 1'b0; wb_i = 1'b0; rd_num_i = '0;
        src_use_i = '0; rs_num_i = '0; rt_num_i = '0; lat_i = '0;
        ret_i = 1'b0; ret_num_i = '0;

        // Reset
        step(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        idle(0, 0);

        // Back-to-back independent ops
        step(1, 0, 1, 1, 1, 2'b00, 0, 0, 1, 0, 0);
        step(1, 0, 1, 1, 2, 2'b10, 3, 0, 1, 1, 1);
        idle(2, 1);
        idle(0, 0);

        // RAW on r5 with retire in the stall cycle (no bypass)
        step(1, 0, 1, 1, 5, 2'b00, 0, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0, 2'b10, 5, 0, 1, 1, 5);
        step(1, 0, 1, 0, 0, 2'b10, 5, 0, 1, 0, 0);
        idle(0, 0);

        // Multi-cycle lat=4, then lat=0 behaves as single cycle
        step(1, 0, 1, 1, 10, 2'b00, 0, 0, 4, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 11, 2'b01, 0, 12, 1, 0, 0);
        idle(10, 1);
        step(1, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 2'b00, 0, 0, 1, 0, 0);
        idle(0, 0);

        // Zero register never pending; WAW on r7
        step(1, 0, 1, 1, 0, 2'b00, 0, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0, 2'b11, 0, 0, 1, 0, 0);
        step(1, 0, 1, 1, 7, 2'b00, 0, 0, 1, 0, 0);
        step(1, 0, 1, 1, 7, 2'b00, 0, 0, 1, 0, 0);
        step(1, 0, 1, 1, 7, 2'b00, 0, 0, 1, 1, 7);
        step(1, 0, 1, 1, 7, 2'b00, 0, 0, 1, 0, 0);
        idle(7, 1);
        idle(0, 1);

        // Flush during BUSY with r4 pending; retire of non-pending r12 ignored
        step(1, 0, 1, 1, 4, 2'b00, 0, 0, 5, 0, 0);
        step(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 1, 2'b00, 0, 0, 1, 1, 12);
        idle(0, 0);

        // Bad retire of r9 -> sticky error
        idle(9, 1);
        idle(0, 0);
        idle(0, 0);

        // Reset mid-BUSY with a well-populated scoreboard
        for (int i = 1; i < 7; i++) step(1, 0, 1, 1, i, 2'b00, 0, 0, 1, 0, 0);
        step(1, 0, 1, 1, 7, 2'b00, 0, 0, 3, 0, 0);
        step(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        idle(0, 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            pl.delete();
            for (int i = 0; i < NREG; i++) if (pm[i]) pl.push_back(i);
            r   = ($urandom % 200) != 0;
            f   = ($urandom % 50) == 0;
            v   = ($urandom % 4) != 0;
            wb  = ($urandom % 3) != 0;
            rd  = int'($urandom % 8);
            su  = 2'($urandom % 4);
            rs  = int'($urandom % 8);
            rt  = int'($urandom % 8);
            lat = (($urandom % 4) == 0) ? int'($urandom % 8) : int'($urandom % 2);
            rn  = int'($urandom % 32);
            ret = 1'b0;
            if (pl.size() > 0 && ($urandom % 2) == 1) begin
                ret = 1'b1;
                rn  = pl[$urandom % pl.size()];
            end else if (($urandom % 80) == 0) begin
                ret = 1'b1;
            end
            step(r, f, v, wb, rd, su, rs, rt, lat, ret, rn);
        end

        idle(0, 0);
        repeat (3) @(negedge clk);
        #4;
        chk("queue_drained", cyc, NREG'(q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
